// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write-back and ID read-port bundle; master drives write-back/read indices, slave returns data, wb_data_out, wb_we_out, wb_count
interface wb_regfile_if #(parameter int WIDTH = 32, parameter int NREG_LOG2 = 5);
  logic RegWrite_in;
  logic MemtoReg_in;
  logic [WIDTH-1:0] D_MEM_read_data_in;
  logic [WIDTH-1:0] D_MEM_read_addr_in;
  logic [NREG_LOG2-1:0] MEM_WB_RegisterRd_in;
  logic [NREG_LOG2-1:0] read_reg1;
  logic [NREG_LOG2-1:0] read_reg2;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] read_data2;
  logic [WIDTH-1:0] wb_data_out;
  logic wb_we_out;
  logic [31:0] wb_count;
  modport master(
    output RegWrite_in, MemtoReg_in, D_MEM_read_data_in, D_MEM_read_addr_in, MEM_WB_RegisterRd_in, read_reg1, read_reg2,
    input read_data1, read_data2, wb_data_out, wb_we_out, wb_count
  );
  modport slave(
    input RegWrite_in, MemtoReg_in, D_MEM_read_data_in, D_MEM_read_addr_in, MEM_WB_RegisterRd_in, read_reg1, read_reg2,
    output read_data1, read_data2, wb_data_out, wb_we_out, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux + 2^NREG_LOG2 x WIDTH register file (r0 hardwired 0), ports clk, rst (sync active-high), bus (wb_regfile_if.slave); define REGFILE_BYPASS_EN for write-through read bypass
module wb_regfile #(parameter int WIDTH = 32, parameter int NREG_LOG2 = 5) (
  input logic clk,
  input logic rst,
  wb_regfile_if.slave bus
);
  localparam int NREG = 1 << NREG_LOG2;
  logic [WIDTH-1:0] regs [NREG];
  logic [31:0] cnt;
  assign bus.wb_data_out = bus.MemtoReg_in ? bus.D_MEM_read_data_in : bus.D_MEM_read_addr_in;
  assign bus.wb_we_out = bus.RegWrite_in && (bus.MEM_WB_RegisterRd_in != '0);
  assign bus.wb_count = cnt;
`ifdef REGFILE_BYPASS_EN
  assign bus.read_data1 = (bus.read_reg1 == '0) ? '0 :
                          (bus.wb_we_out && bus.read_reg1 == bus.MEM_WB_RegisterRd_in) ? bus.wb_data_out : regs[bus.read_reg1];
  assign bus.read_data2 = (bus.read_reg2 == '0) ? '0 :
                          (bus.wb_we_out && bus.read_reg2 == bus.MEM_WB_RegisterRd_in) ? bus.wb_data_out : regs[bus.read_reg2];
`else
  assign bus.read_data1 = (bus.read_reg1 == '0) ? '0 : regs[bus.read_reg1];
  assign bus.read_data2 = (bus.read_reg2 == '0) ? '0 : regs[bus.read_reg2];
`endif
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cnt <= '0;
    end else if (bus.wb_we_out) begin
      regs[bus.MEM_WB_RegisterRd_in] <= bus.wb_data_out;
      cnt <= cnt + 32'd1;
    end
endmodule
